// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: opcodes, ALU codes, FSM states.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_MEM,
    BRANCH,
    JUMP,
    HALT,
    FAULT
  } ctrlState_t;

  // States in which the controller waits on the memory handshake.
  function automatic logic isMemWait(ctrlState_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles and flags the cycle that reaches the limit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] waitCount;

  // The current not-ready cycle is the MEM_TIMEOUT-th one when MEM_TIMEOUT-1 preceded it.
  assign timeout = active && !ready && (waitCount == CW'(MEM_TIMEOUT - 1));

  // Consecutive-wait counter, cleared on ready, on leaving a wait state, or on reset.
  always_ff @(posedge Clk) begin
    if (Reset || !active || ready) begin
      waitCount <= '0;
    end else begin
      waitCount <= waitCount + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback per opcode.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH  = 6,
  parameter int ALU_SEL_WIDTH = 3,
  parameter int MEM_TIMEOUT   = 15,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [OPCODE_WIDTH-1:0]  opcode,
  input  logic [ALU_SEL_WIDTH-1:0] Funct,
  input  logic                     Zero,
  input  logic                     MemReady,
  output logic                     PCWriteCond,
  output logic                     PCWrite,
  output logic                     MemAddr,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     ALUSrcA,
  output logic                     RegWrite,
  output logic [1:0]               MemtoReg,
  output logic [1:0]               BranchCond,
  output logic [1:0]               PCSource,
  output logic [1:0]               ALUSrcB,
  output logic [ALU_SEL_WIDTH-1:0] ALUSelect,
  output logic                     Halted,
  output logic                     Fault,
  output logic                     FaultCause,
  output logic [COUNT_WIDTH-1:0]   InstrCount
);

  ctrlState_t state;
  logic       timeout;
  logic       faultCause;
  logic [COUNT_WIDTH-1:0] instrCount;

  // Branch resolution happens in the datapath; the flag is not needed here.
  logic unusedZero;
  assign unusedZero = Zero;

  logic isR, isAddi, isLw, isSw, isBeq, isBne, isJ, isHalt;
  assign isR    = (opcode == OPCODE_WIDTH'(OP_RTYPE));
  assign isAddi = (opcode == OPCODE_WIDTH'(OP_ADDI));
  assign isLw   = (opcode == OPCODE_WIDTH'(OP_LW));
  assign isSw   = (opcode == OPCODE_WIDTH'(OP_SW));
  assign isBeq  = (opcode == OPCODE_WIDTH'(OP_BEQ));
  assign isBne  = (opcode == OPCODE_WIDTH'(OP_BNE));
  assign isJ    = (opcode == OPCODE_WIDTH'(OP_J));
  assign isHalt = (opcode == OPCODE_WIDTH'(OP_HALT));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) waitTimer (
    .Clk    (Clk),
    .Reset  (Reset),
    .active (isMemWait(state)),
    .ready  (MemReady),
    .timeout(timeout)
  );

  // State sequencing, fault cause capture and retired-instruction count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= FETCH;
      faultCause <= 1'b0;
      instrCount <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (MemReady) begin
            state      <= DECODE;
            instrCount <= instrCount + COUNT_WIDTH'(1);
          end else if (timeout) begin
            state      <= FAULT;
            faultCause <= 1'b1;
          end
        end
        DECODE: begin
          if (isR)                 state <= EXEC_R;
          else if (isAddi)         state <= EXEC_I;
          else if (isLw || isSw)   state <= MEM_ADDR;
          else if (isBeq || isBne) state <= BRANCH;
          else if (isJ)            state <= JUMP;
          else if (isHalt)         state <= HALT;
          else begin
            state      <= FAULT;
            faultCause <= 1'b0;
          end
        end
        EXEC_R, EXEC_I: state <= WB_ALU;
        MEM_ADDR:       state <= isLw ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (MemReady) begin
            state <= WB_MEM;
          end else if (timeout) begin
            state      <= FAULT;
            faultCause <= 1'b1;
          end
        end
        MEM_WR: begin
          if (MemReady) begin
            state <= FETCH;
          end else if (timeout) begin
            state      <= FAULT;
            faultCause <= 1'b1;
          end
        end
        WB_ALU, WB_MEM, BRANCH, JUMP: state <= FETCH;
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FETCH;
      endcase
    end
  end

  // Control decode is combinational because FETCH must react to MemReady in the same cycle;
  // holding Reset blanks every control so no write or memory request escapes mid-access.
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    MemAddr     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 2'b00;
    BranchCond  = 2'b00;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUSelect   = ALU_SEL_WIDTH'(ALU_ADD);
    if (!Reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'b01;
          end
        end
        DECODE: ALUSrcB = 2'b11;
        EXEC_R: begin
          ALUSrcA   = 1'b1;
          ALUSelect = Funct;
        end
        EXEC_I, MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_RD: begin
          MemAddr = 1'b1;
          MemRead = 1'b1;
        end
        MEM_WR: begin
          MemAddr  = 1'b1;
          MemWrite = 1'b1;
        end
        WB_ALU: RegWrite = 1'b1;
        WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        BRANCH: begin
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          BranchCond  = isBne ? 2'b01 : 2'b00;
          ALUSrcA     = 1'b1;
          ALUSelect   = ALU_SEL_WIDTH'(ALU_SUB);
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign Halted     = (state == HALT);
  assign Fault      = (state == FAULT);
  assign FaultCause = faultCause;
  assign InstrCount = instrCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-level bench for multicycle_control with an expected-path model.
module tb_multicycle_control;

  localparam int TO = 15;
  localparam int CW = 4;

  localparam logic [5:0] R_OP = 6'h00, ADDI_OP = 6'h08, LW_OP = 6'h23, SW_OP = 6'h2B;
  localparam logic [5:0] BEQ_OP = 6'h04, BNE_OP = 6'h05, J_OP = 6'h02, HALT_OP = 6'h3F;

  typedef struct packed {
    logic pcwc, pcw, maddr, mrd, mwr, irw, asa, rw;
    logic [1:0] m2r, bc, pcs, asb;
    logic [2:0] alu;
    logic halted, fault;
  } ctl_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [2:0] Funct = '0;
  logic Zero = 1'b0;
  logic MemReady = 1'b0;
  logic PCWriteCond, PCWrite, MemAddr, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] MemtoReg, BranchCond, PCSource, ALUSrcB;
  logic [2:0] ALUSelect;
  logic Halted, Fault, FaultCause;
  logic [CW-1:0] InstrCount;

  multicycle_control #(
    .OPCODE_WIDTH (6),
    .ALU_SEL_WIDTH(3),
    .MEM_TIMEOUT  (TO),
    .COUNT_WIDTH  (CW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .opcode(opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWriteCond(PCWriteCond), .PCWrite(PCWrite),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .BranchCond(BranchCond), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUSelect(ALUSelect), .Halted(Halted), .Fault(Fault),
    .FaultCause(FaultCause), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  ctl_t act;
  always_comb act = {PCWriteCond, PCWrite, MemAddr, MemRead, MemWrite, IRWrite, ALUSrcA,
                     RegWrite, MemtoReg, BranchCond, PCSource, ALUSrcB, ALUSelect, Halted, Fault};

  int checks = 0;
  int failures = 0;
  int expCount = 0;
  logic [5:0] curOp = '0;
  logic [2:0] curFunct = '0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t zc();
    return '0;
  endfunction

  function automatic bit isLegal(logic [5:0] op);
    return op inside {R_OP, ADDI_OP, LW_OP, SW_OP, BEQ_OP, BNE_OP, J_OP, HALT_OP};
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare controls shortly after.
  task automatic cycle(input string tag, input ctl_t exp, input logic rdy);
    @(negedge Clk);
    Reset    = 1'b0;
    opcode   = curOp;
    Funct    = curFunct;
    Zero     = 1'($urandom_range(0, 1));
    MemReady = rdy;
    #1;
    checkEq(tag, 32'(act), 32'(exp));
  endtask

  // Holds Reset for two edges; returns with Reset still high so the next cycle releases it.
  task automatic doReset();
    @(negedge Clk);
    Reset    = 1'b1;
    MemReady = 1'($urandom_range(0, 1));
    #1;
    checkEq("rstWriteEnables",
            32'({PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead}), 32'h0);
    @(negedge Clk);
    MemReady = 1'($urandom_range(0, 1));
    #1;
    checkEq("rstCtl", 32'(act), 32'h0);
    checkEq("rstCount", 32'(InstrCount), 32'h0);
    checkEq("rstFaultCause", 32'(FaultCause), 32'h0);
    expCount = 0;
  endtask

  // Memory handshake phase: `waits` not-ready cycles then ready, unless the limit trips first.
  task automatic waitPhase(input string tag, input ctl_t waitCtl, input ctl_t rdyCtl,
                           input int waits, output bit timedOut);
    timedOut = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (i == waits) begin
        cycle(tag, rdyCtl, 1'b1);
        return;
      end
      cycle(tag, waitCtl, 1'b0);
    end
    timedOut = 1'b1;
  endtask

  // Sticky end state: observe a few cycles, then reset out of it.
  task automatic terminal(input bit halted, input logic cause);
    ctl_t c;
    c = zc();
    c.halted = halted;
    c.fault  = !halted;
    for (int i = 0; i < 3; i++) begin
      cycle(halted ? "haltHold" : "faultHold", c, 1'($urandom_range(0, 1)));
      if (!halted) checkEq("faultCause", 32'(FaultCause), 32'(cause));
    end
    doReset();
  endtask

  task automatic wbAlu();
    ctl_t c;
    c = zc();
    c.rw = 1'b1;
    cycle("wbAlu", c, 1'($urandom_range(0, 1)));
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [2:0] fn, input int fw,
                          input int mw, input bit abortMem);
    ctl_t c, r;
    bit to;
    curOp = op;
    curFunct = fn;
    c = zc();
    c.mrd = 1'b1;
    r = c;
    r.irw = 1'b1;
    r.pcw = 1'b1;
    r.asb = 2'b01;
    waitPhase("fetch", c, r, fw, to);
    if (to) begin
      terminal(1'b0, 1'b1);
      return;
    end
    expCount = (expCount + 1) % (1 << CW);
    c = zc();
    c.asb = 2'b11;
    cycle("decode", c, 1'($urandom_range(0, 1)));
    checkEq("instrCount", 32'(InstrCount), 32'(expCount));
    if (op == R_OP || op == ADDI_OP) begin
      c = zc();
      c.asa = 1'b1;
      if (op == R_OP) c.alu = fn;
      else c.asb = 2'b10;
      cycle("exec", c, 1'($urandom_range(0, 1)));
      wbAlu();
    end else if (op == LW_OP || op == SW_OP) begin
      c = zc();
      c.asa = 1'b1;
      c.asb = 2'b10;
      cycle("memAddr", c, 1'($urandom_range(0, 1)));
      c = zc();
      c.maddr = 1'b1;
      if (op == LW_OP) c.mrd = 1'b1;
      else c.mwr = 1'b1;
      if (abortMem) begin
        cycle("memAbort", c, 1'b0);
        doReset();
        return;
      end
      waitPhase("memAccess", c, c, mw, to);
      if (to) begin
        terminal(1'b0, 1'b1);
        return;
      end
      if (op == LW_OP) begin
        c = zc();
        c.rw  = 1'b1;
        c.m2r = 2'b01;
        cycle("wbMem", c, 1'($urandom_range(0, 1)));
      end
    end else if (op == BEQ_OP || op == BNE_OP) begin
      c = zc();
      c.pcwc = 1'b1;
      c.pcs  = 2'b01;
      c.bc   = (op == BNE_OP) ? 2'b01 : 2'b00;
      c.asa  = 1'b1;
      c.alu  = 3'd1;
      cycle("branch", c, 1'($urandom_range(0, 1)));
    end else if (op == J_OP) begin
      c = zc();
      c.pcw = 1'b1;
      c.pcs = 2'b10;
      cycle("jump", c, 1'($urandom_range(0, 1)));
    end else if (op == HALT_OP) begin
      terminal(1'b1, 1'b0);
    end else begin
      terminal(1'b0, 1'b0);
    end
  endtask

  function automatic int pickWait();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 6) return TO + int'($urandom_range(0, 1));
    if (r < 55) return 0;
    return int'($urandom_range(1, 4));
  endfunction

  function automatic logic [5:0] pickOp();
    int r;
    logic [5:0] x;
    r = int'($urandom_range(0, 99));
    if (r < 18) return R_OP;
    if (r < 32) return ADDI_OP;
    if (r < 48) return LW_OP;
    if (r < 60) return SW_OP;
    if (r < 70) return BEQ_OP;
    if (r < 80) return BNE_OP;
    if (r < 92) return J_OP;
    if (r < 95) return HALT_OP;
    x = 6'($urandom_range(0, 63));
    if (isLegal(x)) x = 6'h3E;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    doReset();
    // Directed paths.
    runInstr(R_OP, 3'd5, 0, 0, 1'b0);
    runInstr(LW_OP, 3'd0, 0, 3, 1'b0);
    runInstr(SW_OP, 3'd0, 1, 0, 1'b0);
    runInstr(BEQ_OP, 3'd0, 0, 0, 1'b0);
    runInstr(BNE_OP, 3'd0, 0, 0, 1'b0);
    runInstr(ADDI_OP, 3'd2, 2, 0, 1'b0);
    runInstr(J_OP, 3'd0, 0, 0, 1'b0);
    runInstr(R_OP, 3'd0, TO, 0, 1'b0);
    runInstr(6'h3E, 3'd0, 0, 0, 1'b0);
    runInstr(LW_OP, 3'd0, 0, TO, 1'b0);
    runInstr(HALT_OP, 3'd0, 0, 0, 1'b0);
    runInstr(SW_OP, 3'd0, 0, 0, 1'b1);
    runInstr(ADDI_OP, 3'd0, TO - 1, 0, 1'b0);
    // Enough back-to-back jumps to wrap the narrow counter.
    for (int i = 0; i < 18; i++) runInstr(J_OP, 3'd0, 0, 0, 1'b0);
    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      runInstr(pickOp(), 3'($urandom_range(0, 7)), pickWait(), pickWait(), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 6, instruction opcode width.
REQ-002 SHALL have parameter ALU_SEL_WIDTH, default 3, ALU operation select width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, maximum memory wait cycles (minimum 1).
REQ-004 SHALL have parameter COUNT_WIDTH, default 16, retired-instruction counter width.
REQ-005 SHALL have ports, clock and reset first; one clock, synchronous active-high reset:
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_WIDTH  opcode from instruction register.
- Funct  in  ALU_SEL_WIDTH  R-type ALU op field.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes access this cycle.
- PCWriteCond, PCWrite, MemAddr, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite  out  1  datapath controls.
- MemtoReg, BranchCond, PCSource, ALUSrcB  out  2  datapath mux selects.
- ALUSelect  out  ALU_SEL_WIDTH  ALU operation.
- Halted  out  1  HALT executed.
- Fault  out  1  sticky: illegal opcode or memory timeout.
- FaultCause  out  1  0 = illegal opcode, 1 = timeout.
- InstrCount  out  COUNT_WIDTH  instructions fetched.

Function
REQ-006 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT, FAULT.
REQ-007 SHALL decode opcodes: 0x00 R-type, 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x05 BNE, 0x02 J, 0x3F HALT; any other opcode in DECODE SHALL go to FAULT with FaultCause=0.
REQ-008 SHALL, in FETCH, assert MemRead, MemAddr=0; when MemReady=1 in the same cycle assert IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, PCSource=00, ALUSelect=ADD, then go to DECODE; otherwise remain in FETCH.
REQ-009 SHALL, in DECODE, drive ALUSrcA=0, ALUSrcB=11 (branch target), ALUSelect=ADD, then branch on opcode: R->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ/BNE->BRANCH, J->JUMP, HALT->HALT.
REQ-010 SHALL drive ALUSelect=Funct in EXEC_R, ADD in EXEC_I/MEM_ADDR, SUB in BRANCH; ALUSrcA=1 and ALUSrcB=00 (EXEC_R, BRANCH) or 10 (EXEC_I, MEM_ADDR).
REQ-011 SHALL assert PCWriteCond, PCSource=01 in BRANCH, BranchCond=00 (BEQ) or 01 (BNE); PCWrite, PCSource=10 in JUMP; both return to FETCH.
REQ-012 SHALL, in MEM_RD/MEM_WR, hold MemAddr=1 and MemRead/MemWrite until MemReady=1; MEM_RD->WB_MEM, MEM_WR->FETCH on ready.
REQ-013 SHALL assert RegWrite with MemtoReg=00 in WB_ALU and MemtoReg=01 in WB_MEM, then go to FETCH.
REQ-014 SHALL require zero-wait latencies: R/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3.
REQ-015 SHALL count consecutive not-ready cycles in FETCH/MEM_RD/MEM_WR, clearing on ready or state exit; on reaching MEM_TIMEOUT SHALL go to FAULT with FaultCause=1.
REQ-016 SHALL hold HALT and FAULT until Reset; both deassert all write enables and memory requests; Halted=1 in HALT, Fault=1 in FAULT.
REQ-017 SHALL increment InstrCount on each FETCH ready cycle, wrapping modulo 2^COUNT_WIDTH.
REQ-018 SHALL drive all unlisted controls to 0 in every state.

Reset
REQ-019 SHALL, when Reset=1 at an edge (including mid-access), enter FETCH and clear wait counter, InstrCount, Fault, FaultCause, Halted.
REQ-020 SHALL force PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead to 0 while Reset=1.

Structure
REQ-021 SHALL place opcode constants, the state encoding and ALU codes (ADD=0, SUB=1) in shared package cpu_ctrl_pkg.
REQ-022 SHALL implement the timeout counter as sub-module mem_wait_timer.

Verification
REQ-023 SHALL test R-type, MemReady=1 constantly: FETCH, DECODE, EXEC_R, WB_ALU; RegWrite=1 in cycle 4; InstrCount=1.
REQ-024 SHALL test LW with MemReady low 3 cycles in MEM_RD: MemRead held 4 cycles, then WB_MEM, MemtoReg=01.
REQ-025 SHALL test MemReady held low 15 cycles in FETCH: FAULT, Fault=1, FaultCause=1, no IRWrite.
REQ-026 SHALL test opcode 0x3E: DECODE->FAULT, FaultCause=0; BNE: PCWriteCond=1, BranchCond=01, PCSource=01.
REQ-027 SHALL test HALT then Reset pulse: Halted=1 until reset, then FETCH, InstrCount=0; Reset during MEM_WR aborts with MemWrite=0.
